// File: rtl/rv32_encoder.sv
// rv32_encoder
//   Turns decoded-field descriptors back into RV32IM machine words and hands
//   them to an instruction-memory write port with sequential word addresses.
//   Illegal descriptors are consumed without emitting a word and are counted.
//   A HALT descriptor emits HALT_WORD and ends the program.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse that begins a program (IDLE or DONE)
//   in_valid/ready  descriptor handshake
//   in_class        0 OPIMM, 1 OP, 2 LUI, 3 AUIPC, 4 JAL, 5 JALR, 6 BRANCH,
//                   7 STORE, 8 LOAD, 9 HALT, 10-15 illegal
//   in_funct3       funct3 field
//   in_alt          funct7=0100000 variant (SUB/SRA/SRAI)
//   in_mext         funct7=0000001 (M extension, OP class only)
//   in_rd/rs1/rs2   register numbers
//   in_imm          immediate in natural bit positions
//   out_valid/ready output word handshake
//   out_word        encoded instruction
//   out_addr        address of out_word
//   done            program finished and the last word has drained
//   err             sticky illegal-descriptor flag
//   err_count       illegal descriptors seen, saturating at 255

module rv32_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0]       HALT_WORD = 32'h00000073
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic              in_mext,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] CLS_OPIMM  = 4'd0;
  localparam logic [3:0] CLS_OP     = 4'd1;
  localparam logic [3:0] CLS_LUI    = 4'd2;
  localparam logic [3:0] CLS_AUIPC  = 4'd3;
  localparam logic [3:0] CLS_JAL    = 4'd4;
  localparam logic [3:0] CLS_JALR   = 4'd5;
  localparam logic [3:0] CLS_BRANCH = 4'd6;
  localparam logic [3:0] CLS_STORE  = 4'd7;
  localparam logic [3:0] CLS_LOAD   = 4'd8;
  localparam logic [3:0] CLS_HALT   = 4'd9;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_word_q, out_word_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              err_q, err_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              restart_q, restart_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        enc_halt;
  logic        accept;
  logic        out_free;

  // Immediate range checks: each format's immediate must be the sign
  // extension of its top encoded bit, otherwise bits would be silently lost.
  logic imm_i_ok, imm_b_ok, imm_j_ok, imm_u_ok, shamt_ok, is_shift;
  logic [6:0] op_funct7;

  assign imm_i_ok  = (in_imm[31:11] == {21{in_imm[11]}});
  assign imm_b_ok  = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
  assign imm_j_ok  = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
  assign imm_u_ok  = (in_imm[11:0] == 12'd0);
  assign shamt_ok  = (in_imm[31:5] == 27'd0);
  assign is_shift  = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
  assign op_funct7 = in_mext ? F7_MEXT : (in_alt ? F7_ALT : F7_ZERO);

  // Handshake: the output register is free when empty or draining this cycle,
  // so a new descriptor may be taken in the same cycle the old word leaves.
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == ST_RUN) && out_free;
  assign accept   = in_valid && in_ready;

  // Field packing and legality for the descriptor currently on the input.
  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b0;
    enc_halt  = 1'b0;
    case (in_class)
      CLS_OPIMM: begin
        if (is_shift) begin
          enc_word  = {in_alt ? F7_ALT : F7_ZERO, in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
          enc_legal = shamt_ok && (!in_alt || (in_funct3 == 3'b101));
        end else begin
          enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
          enc_legal = imm_i_ok && !in_alt;
        end
      end
      CLS_OP: begin
        enc_word  = {op_funct7, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
        enc_legal = !(in_alt && in_mext) &&
                    !(in_alt && (in_funct3 != 3'b000) && (in_funct3 != 3'b101));
      end
      CLS_LUI: begin
        enc_word  = {in_imm[31:12], in_rd, OPC_LUI};
        enc_legal = imm_u_ok;
      end
      CLS_AUIPC: begin
        enc_word  = {in_imm[31:12], in_rd, OPC_AUIPC};
        enc_legal = imm_u_ok;
      end
      CLS_JAL: begin
        enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
        enc_legal = imm_j_ok;
      end
      CLS_JALR: begin
        enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_JALR};
        enc_legal = imm_i_ok && (in_funct3 == 3'b000);
      end
      CLS_BRANCH: begin
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], OPC_BRANCH};
        enc_legal = imm_b_ok && (in_funct3 != 3'b010) && (in_funct3 != 3'b011);
      end
      CLS_STORE: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
        enc_legal = imm_i_ok && (in_funct3 <= 3'b010);
      end
      CLS_LOAD: begin
        enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
        enc_legal = imm_i_ok && (in_funct3 != 3'b011) &&
                    (in_funct3 != 3'b110) && (in_funct3 != 3'b111);
      end
      CLS_HALT: begin
        enc_word  = HALT_WORD;
        enc_legal = 1'b1;
        enc_halt  = 1'b1;
      end
      default: begin
        enc_word  = 32'd0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // Next-state logic for the program sequencer and the output register.
  // A start seen in DONE while the last word is still stalled is remembered
  // in restart_q so the pulse is not lost and the word completes first.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_addr_d  = out_addr_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    restart_d   = restart_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (enc_legal) begin
        out_valid_d = 1'b1;
        out_word_d  = enc_word;
        out_addr_d  = pc_q;
        pc_d        = pc_q + ADDR_W'(4);
        if (enc_halt) begin
          state_d = ST_DONE;
        end
      end else begin
        err_d = 1'b1;
        if (err_count_q != 8'hFF) begin
          err_count_d = err_count_q + 8'd1;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          pc_d        = BASE_ADDR;
          err_d       = 1'b0;
          err_count_d = 8'd0;
        end
      end
      ST_DONE: begin
        if (start || restart_q) begin
          if (out_free) begin
            state_d     = ST_RUN;
            pc_d        = BASE_ADDR;
            err_d       = 1'b0;
            err_count_d = 8'd0;
            restart_d   = 1'b0;
          end else begin
            restart_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // State registers; reset discards any pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= BASE_ADDR;
      out_valid_q <= 1'b0;
      out_word_q  <= 32'd0;
      out_addr_q  <= '0;
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
      restart_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_addr_q  <= out_addr_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      restart_q   <= restart_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign done      = (state_q == ST_DONE) && !out_valid_q;

endmodule

// File: tb/tb_rv32_encoder.sv
// tb_rv32_encoder
//   Self-checking bench for rv32_encoder. Descriptors are driven one cycle
//   at a time; every accepted legal descriptor pushes its expected word and
//   address into a scoreboard queue, and the output monitor pops and compares
//   whenever a word leaves the encoder. A narrow 8-bit address is used so the
//   address wrap is reachable in a short run.

module tb_rv32_encoder;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_class;
  logic [2:0]    in_funct3;
  logic          in_alt;
  logic          in_mext;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_word;
  logic [AW-1:0] out_addr;
  logic          done;
  logic          err;
  logic [7:0]    err_count;

  rv32_encoder #(
    .ADDR_W   (AW),
    .BASE_ADDR(8'h00),
    .HALT_WORD(32'h00000073)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_class (in_class),
    .in_funct3(in_funct3),
    .in_alt   (in_alt),
    .in_mext  (in_mext),
    .in_rd    (in_rd),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_imm   (in_imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word),
    .out_addr (out_addr),
    .done     (done),
    .err      (err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int            checkCount = 0;
  int            errorCount = 0;
  logic [31:0]   expWord[$];
  logic [AW-1:0] expAddr[$];
  logic [AW-1:0] tbPc;
  int            errExp;
  logic          randReady;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference encoder written from the instruction formats, using signed
  // range tests for immediate legality. Returns {legal, word}.
  function automatic logic [32:0] modelEncode(input logic [3:0] cls, input logic [2:0] f3,
                                              input logic alt, input logic mext,
                                              input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    logic        ok;
    int signed   si;
    logic        in12, in13, in21;
    si   = $signed(imm);
    in12 = (si >= -2048) && (si <= 2047);
    in13 = (si >= -4096) && (si <= 4095);
    in21 = (si >= -1048576) && (si <= 1048575);
    w  = 32'd0;
    ok = 1'b0;
    case (cls)
      4'd0: begin
        w[6:0] = 7'h13; w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          w[24:20] = imm[4:0];
          w[31:25] = alt ? 7'h20 : 7'h00;
          ok = (imm < 32) && (!alt || f3 == 3'd5);
        end else begin
          w[31:20] = imm[11:0];
          ok = in12 && !alt;
        end
      end
      4'd1: begin
        w[6:0] = 7'h33; w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2;
        if (mext) w[31:25] = 7'h01;
        else if (alt) w[31:25] = 7'h20;
        ok = !(alt && mext) && !(alt && f3 != 3'd0 && f3 != 3'd5);
      end
      4'd2, 4'd3: begin
        w[6:0] = (cls == 4'd2) ? 7'h37 : 7'h17;
        w[11:7] = rd; w[31:12] = imm[31:12];
        ok = (imm[11:0] == 12'h000);
      end
      4'd4: begin
        w[6:0] = 7'h6F; w[11:7] = rd;
        w[31] = imm[20]; w[30:21] = imm[10:1]; w[20] = imm[11]; w[19:12] = imm[19:12];
        ok = in21 && !imm[0];
      end
      4'd5: begin
        w[6:0] = 7'h67; w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[31:20] = imm[11:0];
        ok = in12 && (f3 == 3'd0);
      end
      4'd6: begin
        w[6:0] = 7'h63; w[7] = imm[11]; w[11:8] = imm[4:1]; w[14:12] = f3;
        w[19:15] = rs1; w[24:20] = rs2; w[30:25] = imm[10:5]; w[31] = imm[12];
        ok = in13 && !imm[0] && (f3 != 3'd2) && (f3 != 3'd3);
      end
      4'd7: begin
        w[6:0] = 7'h23; w[11:7] = imm[4:0]; w[14:12] = f3;
        w[19:15] = rs1; w[24:20] = rs2; w[31:25] = imm[11:5];
        ok = in12 && (f3 < 3'd3);
      end
      4'd8: begin
        w[6:0] = 7'h03; w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[31:20] = imm[11:0];
        ok = in12 && !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      4'd9: begin
        w  = 32'h00000073;
        ok = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  // Drives one descriptor (entered just after a rising edge) and holds it
  // until accepted. A known reference word may replace the model result.
  task automatic applyStimulus(input logic [3:0] cls, input logic [2:0] f3,
                               input logic alt, input logic mext,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm,
                               input logic hasRef, input logic [31:0] refWord);
    logic [32:0] m;
    bit          accepted;
    in_class = cls; in_funct3 = f3; in_alt = alt; in_mext = mext;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int c = 0; c < 64 && !accepted; c++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        m = modelEncode(cls, f3, alt, mext, rd, rs1, rs2, imm);
        if (hasRef) m = {1'b1, refWord};
        if (m[32]) begin
          expWord.push_back(m[31:0]);
          expAddr.push_back(tbPc);
          tbPc = tbPc + AW'(4);
        end else if (errExp != 255) begin
          errExp++;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    tbPc   = '0;
    errExp = 0;
  endtask

  // Output monitor: a word transfers on the next rising edge whenever
  // out_valid and out_ready are both high at the falling edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expWord.size() == 0) begin
        checkOutput("unexpected_word", out_word, 32'hFFFFFFFF);
      end else begin
        checkOutput("word", out_word, expWord.pop_front());
        checkOutput("addr", {24'd0, out_addr}, {24'd0, expAddr.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [3:0]  rCls;
  logic [31:0] rImm;
  logic [31:0] rRaw;
  logic [AW-1:0] stallAddr;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_class = '0; in_funct3 = '0; in_alt = 1'b0; in_mext = 1'b0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    tbPc = '0; errExp = 0; randReady = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_word", out_word, 32'd0);
    checkOutput("rst_out_addr", {24'd0, out_addr}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_err_count", {24'd0, err_count}, 32'd0);
    @(posedge clk);
    #1;

    pulseStart();

    // Two illegal descriptors: no word, error flag and count of two.
    applyStimulus(4'd0, 3'd0, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'd0);
    applyStimulus(4'd6, 3'd2, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd6, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("illegal_no_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("illegal_err", {31'd0, err}, 32'd1);
    checkOutput("illegal_err_count", {24'd0, err_count}, 32'd2);
    @(posedge clk);
    #1;

    // First legal word lands at address 0 one cycle after acceptance.
    applyStimulus(4'd0, 3'd0, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093);
    @(negedge clk);
    checkOutput("latency_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;

    applyStimulus(4'd1, 3'd0, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
    applyStimulus(4'd1, 3'd0, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h402081B3);
    applyStimulus(4'd1, 3'd0, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h022081B3);
    applyStimulus(4'd6, 3'd0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h00208463);
    applyStimulus(4'd4, 3'd0, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800, 1'b1, 32'h001000EF);
    applyStimulus(4'd2, 3'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7);
    applyStimulus(4'd7, 3'd2, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd12, 1'b1, 32'h0020A623);

    // Back-pressure: hold a word for three cycles, then release.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    stallAddr = tbPc;
    applyStimulus(4'd0, 3'd0, 1'b0, 1'b0, 5'd2, 5'd1, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF08113);
    fork
      applyStimulus(4'd3, 3'd0, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0, 32'hABCDE000, 1'b1, 32'hABCDE397);
      begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("stall_word", out_word, 32'hFFF08113);
          checkOutput("stall_addr", {24'd0, out_addr}, {24'd0, stallAddr});
          checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
      end
    join

    // HALT: word, then done once drained.
    applyStimulus(4'd9, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 32'h00000073);
    @(negedge clk);
    @(negedge clk);
    checkOutput("halt_done", {31'd0, done}, 32'd1);
    checkOutput("halt_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    pulseStart();
    @(negedge clk);
    checkOutput("restart_err", {31'd0, err}, 32'd0);
    checkOutput("restart_err_count", {24'd0, err_count}, 32'd0);
    checkOutput("restart_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("restart_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;

    // Randomised descriptors with random output back-pressure.
    randReady = 1'b1;
    fork
      while (randReady) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 3) != 0);
      end
      begin
        for (int n = 0; n < 80; n++) begin
          rCls = 4'($urandom_range(0, 15));
          if (rCls == 4'd9) rCls = 4'd0;
          rRaw = $urandom;
          case ($urandom_range(0, 4))
            0: rImm = {{20{rRaw[11]}}, rRaw[11:0]};
            1: rImm = {rRaw[19:0], 12'd0};
            2: rImm = {{19{rRaw[12]}}, rRaw[12:1], 1'b0};
            3: rImm = {{11{rRaw[20]}}, rRaw[20:1], 1'b0};
            default: rImm = rRaw;
          endcase
          applyStimulus(rCls, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 3) == 0), 5'($urandom), 5'($urandom),
                        5'($urandom), rImm, 1'b0, 32'd0);
        end
        randReady = 1'b0;
      end
    join
    #1 out_ready = 1'b1;

    // Enough legal words to carry the address past the 8-bit wrap.
    for (int n = 0; n < 70; n++) begin
      applyStimulus(4'd0, 3'd0, 1'b0, 1'b0, 5'(n), 5'(n + 1), 5'd0, 32'(n), 1'b0, 32'd0);
    end

    // Error counter saturation.
    for (int n = 0; n < 260; n++) begin
      applyStimulus(4'(10 + (n % 6)), 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0);
    end
    @(negedge clk);
    checkOutput("sat_err", {31'd0, err}, 32'd1);
    checkOutput("sat_err_count", {24'd0, err_count}, 32'(errExp));
    checkOutput("sat_err_count_max", {24'd0, err_count}, 32'd255);
    checkOutput("scoreboard_drained", 32'(expWord.size()), 32'd0);
    @(posedge clk);
    #1;

    // Reset while a word is stalled.
    out_ready = 1'b0;
    applyStimulus(4'd0, 3'd0, 1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 32'd9, 1'b0, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    expWord.delete();
    expAddr.delete();
    @(negedge clk);
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_out_word", out_word, 32'd0);
    checkOutput("midrst_out_addr", {24'd0, out_addr}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("midrst_err_count", {24'd0, err_count}, 32'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
